fp_mul_nr_pipe: RTL and testbench

FP_MUL_NR_PIPE -- requirements
Module: fp_mul_nr_pipe

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_mul_round.sv | 61 ++++++
 rtl/fp_mul_nr_pipe.sv | 123 ++++++++++++
 tb/tb_fp_mul_nr_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared field widths, constants and the unpacked-operand type for the
// unsigned single-precision multiplier.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [EXP_W+MAN_W-1:0] FP_INF = 31'h7F800000;

    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   mant;       // hidden bit included
        logic             is_zero;    // zero or denormal, flushed
        logic             is_special; // Inf or NaN
    } fp_unpacked_t;

    function automatic fp_unpacked_t fp_unpack(input logic [EXP_W+MAN_W-1:0] x);
        fp_unpacked_t f;
        f.exp        = x[EXP_W+MAN_W-1:MAN_W];
        f.is_zero    = (f.exp == '0);
        f.is_special = (f.exp == EXP_W'(EXP_MAX));
        f.mant       = {~f.is_zero, x[MAN_W-1:0]};
        return f;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Normalize, round and pack a 48-bit mantissa product.
// FP_MUL_RNE_EN selects round-to-nearest-even; otherwise the result truncates.
module fp_mul_round
    import fp_pkg::*;
(
    input  logic [47:0]       prod,
    input  logic signed [9:0] exp_in,
    input  logic              is_zero,
    input  logic              is_special,
    output logic [30:0]       result,
    output logic              err
);

    logic              hi;
    logic [MAN_W-1:0]  mant_n;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [24:0]       sig;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;
    logic [MAN_W-1:0]  mant_r;

    assign hi     = prod[47];
    assign mant_n = hi ? prod[46:24] : prod[45:23];
    assign guard  = hi ? prod[23] : prod[22];
    assign sticky = hi ? (|prod[22:0]) : (|prod[21:0]);
    assign exp_n  = exp_in + (hi ? 10'sd1 : 10'sd0);

`ifdef FP_MUL_RNE_EN
    assign inc = guard & (sticky | mant_n[0]);
`else
    logic round_bits_unused;
    assign round_bits_unused = guard | sticky;
    assign inc = 1'b0;
`endif

    // Rounding carry out of the 24-bit significand bumps the exponent again.
    assign sig    = {2'b01, mant_n} + {24'd0, inc};
    assign exp_r  = sig[24] ? exp_n + 10'sd1 : exp_n;
    assign mant_r = sig[24] ? '0 : sig[22:0];

    always_comb begin
        result = '0;
        err    = 1'b0;
        if (is_special) begin
            result = FP_INF;
            err    = 1'b1;
        end else if (is_zero) begin
            result = '0;
        end else if (exp_r >= 10'sd255) begin
            result = FP_INF;
            err    = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            result = '0;
        end else begin
            result = {exp_r[EXP_W-1:0], mant_r};
        end
    end

endmodule

// File: rtl/fp_mul_nr_pipe.sv
// Pipelined unsigned single-precision multiplier: input capture, unpack,
// multiply, round/pack. Rounding mode selected by FP_MUL_RNE_EN.
module fp_mul_nr_pipe
    import fp_pkg::*;
#(
    parameter int PASS_W = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [30:0]       a_in,
    input  logic [30:0]       b_in,
    input  logic [PASS_W-1:0] pass_in,
    input  logic              error_in,
    output logic [30:0]       float_out,
    output logic [PASS_W-1:0] pass_out,
    output logic              ready,
    output logic              error_out
);

    logic v0_reg, v1_reg, v2_reg;

    logic [30:0]       op0_reg [2];
    logic [PASS_W-1:0] pass0_reg, pass1_reg, pass2_reg;
    logic              err0_reg, err1_reg, err2_reg;

    fp_unpacked_t      unp [2];
    logic signed [9:0] exp_sum;
    logic signed [9:0] exp1_reg, exp2_reg;
    logic [MAN_W:0]    ma1_reg, mb1_reg;
    logic              zero1_reg, zero2_reg;
    logic              spec1_reg, spec2_reg;
    logic [47:0]       prod2_reg;

    logic [30:0]       round_res;
    logic              round_err;

    logic [30:0]       float_out_reg;
    logic [PASS_W-1:0] pass_out_reg;
    logic              error_out_reg;
    logic              ready_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_reg        <= 1'b0;
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            ready_reg     <= 1'b0;
            float_out_reg <= '0;
            pass_out_reg  <= '0;
            error_out_reg <= 1'b0;
        end else begin
            v0_reg    <= valid;
            v1_reg    <= v0_reg;
            v2_reg    <= v1_reg;
            ready_reg <= v2_reg;
            if (v2_reg) begin
                float_out_reg <= round_res;
                pass_out_reg  <= pass2_reg;
                error_out_reg <= err2_reg | round_err;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            always_ff @(posedge clk) begin
                if (valid)
                    op0_reg[gi] <= (gi == 0) ? a_in : b_in;
            end
            assign unp[gi] = fp_unpack(op0_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (valid) begin
            pass0_reg <= pass_in;
            err0_reg  <= error_in;
        end
    end

    assign exp_sum = $signed({2'b00, unp[0].exp}) + $signed({2'b00, unp[1].exp})
                   - $signed(10'(BIAS));

    always_ff @(posedge clk) begin
        if (v0_reg) begin
            exp1_reg  <= exp_sum;
            ma1_reg   <= unp[0].mant;
            mb1_reg   <= unp[1].mant;
            zero1_reg <= unp[0].is_zero | unp[1].is_zero;
            spec1_reg <= unp[0].is_special | unp[1].is_special;
            pass1_reg <= pass0_reg;
            err1_reg  <= err0_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (v1_reg) begin
            prod2_reg <= 48'(ma1_reg) * 48'(mb1_reg);
            exp2_reg  <= exp1_reg;
            zero2_reg <= zero1_reg;
            spec2_reg <= spec1_reg;
            pass2_reg <= pass1_reg;
            err2_reg  <= err1_reg;
        end
    end

    fp_mul_round u_round (
        .prod       (prod2_reg),
        .exp_in     (exp2_reg),
        .is_zero    (zero2_reg),
        .is_special (spec2_reg),
        .result     (round_res),
        .err        (round_err)
    );

    assign float_out = float_out_reg;
    assign pass_out  = pass_out_reg;
    assign error_out = error_out_reg;
    assign ready     = ready_reg;

endmodule

// File: tb/tb_fp_mul_nr_pipe.sv
// Self-checking bench for fp_mul_nr_pipe: directed cases plus random operands
// against an integer-arithmetic reference of the multiply rules.
module tb_fp_mul_nr_pipe;

    localparam int PW = 31;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid = 1'b0;
    logic [30:0]   a_in = '0;
    logic [30:0]   b_in = '0;
    logic [PW-1:0] pass_in = '0;
    logic          error_in = 1'b0;
    logic [30:0]   float_out;
    logic [PW-1:0] pass_out;
    logic          ready;
    logic          error_out;

    fp_mul_nr_pipe #(.PASS_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .a_in      (a_in),
        .b_in      (b_in),
        .pass_in   (pass_in),
        .error_in  (error_in),
        .float_out (float_out),
        .pass_out  (pass_out),
        .ready     (ready),
        .error_out (error_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            v;
        logic [30:0]   f;
        logic [PW-1:0] p;
        logic          e;
    } exp_t;

    exp_t          q[$];
    logic [30:0]   last_f = '0;
    logic [PW-1:0] last_p = '0;
    logic          last_e = 1'b0;
    int            n_vec = 0;
    int            n_bad = 0;

`ifdef FP_MUL_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    // Exact product as an integer, then pick the 24 leading bits and round.
    function automatic logic [30:0] ref_mul(input logic [30:0] a, input logic [30:0] b,
                                            output logic err);
        int ea, eb, e, sh;
        longint unsigned ma, mb, p, m, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        err = 1'b0;
        if (ea == 255 || eb == 255) begin
            err = 1'b1;
            return 31'h7F800000;
        end
        if (ea == 0 || eb == 0)
            return 31'h0;
        ma   = 64'(a[22:0]) + (64'd1 << 23);
        mb   = 64'(b[22:0]) + (64'd1 << 23);
        p    = ma * mb;
        sh   = (p >= (64'd1 << 47)) ? 24 : 23;
        e    = ea + eb - 127 + (sh - 23);
        m    = p >> sh;
        rem  = p - (m << sh);
        half = 64'd1 << (sh - 1);
        if (RNE && (rem > half || (rem == half && m[0])))
            m = m + 1;
        if (m == (64'd1 << 24)) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            err = 1'b1;
            return 31'h7F800000;
        end
        if (e <= 0)
            return 31'h0;
        return {e[7:0], m[22:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, enqueue the expected result, check what exits now.
    task automatic tick(input bit v, input logic [30:0] a, input logic [30:0] b,
                        input logic [PW-1:0] p, input logic e);
        exp_t x;
        exp_t y;
        logic lerr;
        valid    = v;
        a_in     = a;
        b_in     = b;
        pass_in  = p;
        error_in = e;
        x.v = v;
        x.f = ref_mul(a, b, lerr);
        x.p = p;
        x.e = e | lerr;
        q.push_back(x);
        @(posedge clk);
        #1;
        if (q.size() > 3) begin
            y = q.pop_front();
            chk("ready", 32'(ready), 32'(y.v));
            if (y.v) begin
                last_f = y.f;
                last_p = y.p;
                last_e = y.e;
            end
            chk("float_out", 32'(float_out), 32'(last_f));
            chk("pass_out", 32'(pass_out), 32'(last_p));
            chk("error_out", 32'(error_out), 32'(last_e));
        end else begin
            chk("ready_fill", 32'(ready), 32'd0);
        end
        $display("txn v=%0b a=%h b=%h pass=%h ei=%0b | ready=%0b float=%h pass=%h eo=%0b",
                 v, a, b, p, e, ready, float_out, pass_out, error_out);
        @(negedge clk);
    endtask

    task automatic idle();
        tick(1'b0, 31'h0, 31'h0, '0, 1'b0);
    endtask

    function automatic logic [30:0] rand_op();
        logic [7:0]  ex;
        logic [22:0] mn;
        int r;
        r  = int'($urandom_range(0, 9));
        mn = 23'($urandom);
        case (r)
            0:       ex = 8'd0;
            1:       ex = 8'd255;
            2:       ex = 8'($urandom_range(1, 20));
            3:       ex = 8'($urandom_range(235, 254));
            default: ex = 8'($urandom_range(100, 154));
        endcase
        return {ex, mn};
    endfunction

    initial begin
        #12;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_float", 32'(float_out), 32'd0);
        chk("rst_pass", 32'(pass_out), 32'd0);
        chk("rst_error", 32'(error_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        tick(1'b1, 31'h3FC00000, 31'h40000000, 31'h12345, 1'b0);
        tick(1'b1, 31'h3F800001, 31'h3FC00000, 31'h00001, 1'b0);
        tick(1'b1, 31'h7F000000, 31'h7F000000, 31'h00002, 1'b0);
        tick(1'b1, 31'h00800000, 31'h00800000, 31'h00003, 1'b0);
        tick(1'b1, 31'h7F800000, 31'h00000000, 31'h00004, 1'b0);
        tick(1'b1, 31'h3F800000, 31'h7FC00000, 31'h00005, 1'b1);
        repeat (4) idle();

        for (int i = 0; i < 10; i++)
            tick(1'b1, rand_op(), rand_op(), PW'(i + 100), logic'(i % 2));
        repeat (2) idle();
        repeat (3) idle();

        // Two samples in flight, then a one-cycle reset pulse.
        tick(1'b1, 31'h40000000, 31'h40000000, 31'h0AAAA, 1'b1);
        tick(1'b1, 31'h40400000, 31'h40000000, 31'h0BBBB, 1'b0);
        valid = 1'b0;
        rst   = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_float", 32'(float_out), 32'd0);
        chk("midrst_pass", 32'(pass_out), 32'd0);
        chk("midrst_error", 32'(error_out), 32'd0);
        q.delete();
        last_f = '0;
        last_p = '0;
        last_e = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick(1'b1, 31'h3FC00000, 31'h3FC00000, 31'h0CCCC, 1'b0);
        repeat (4) idle();

        for (int i = 0; i < 300; i++)
            tick(($urandom_range(0, 3) != 0), rand_op(), rand_op(),
                 PW'($urandom), logic'($urandom_range(0, 1)));
        repeat (4) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
